// File: rtl/pll_pkg.sv
// Shared definitions for the EHXPLLL dynamic phase-step sequencer.
package pll_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    LOCKWAIT,
    DONE
  } pll_state_t;

  localparam logic [1:0] SEL_CLKOS  = 2'd0;
  localparam logic [1:0] SEL_CLKOS2 = 2'd1;
  localparam logic [1:0] SEL_CLKOS3 = 2'd2;
  localparam logic [1:0] SEL_CLKOP  = 2'd3;

  localparam int DEF_SETUP_CYC = 4;
  localparam int DEF_PULSE_CYC = 4;
  localparam int DEF_HOLD_CYC  = 4;
  localparam int DEF_LOCK_TMO  = 65535;

endpackage

// File: rtl/phase_wrap_counter.sv
// Modulo-M up/down phase position counter, one step per enable.
module phase_wrap_counter #(
  parameter int           W = 8,
  parameter logic [W-1:0] M = W'(80)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         dir,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] LAST = M - W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      if (dir) q <= (q == LAST) ? '0 : q + W'(1);
      else     q <= (q == '0) ? LAST : q - W'(1);
    end
  end

endmodule

// File: rtl/pll_phase_stepper.sv
// Sequences PHASESEL/PHASEDIR/PHASESTEP for an ECP5 EHXPLLL and tracks
// the wrapped phase position of each steppable output.
module pll_phase_stepper
  import pll_pkg::*;
#(
  parameter int                       NCH       = 3,
  parameter int                       PHASE_W   = 8,
  parameter logic [NCH*PHASE_W-1:0]   CH_MOD    = {NCH{PHASE_W'(80)}},
  parameter int                       STEP_W    = 8,
  parameter int                       SETUP_CYC = DEF_SETUP_CYC,
  parameter int                       PULSE_CYC = DEF_PULSE_CYC,
  parameter int                       HOLD_CYC  = DEF_HOLD_CYC,
  parameter int                       LOCK_TMO  = DEF_LOCK_TMO
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_ch,
  input  logic                     req_dir,
  input  logic [STEP_W-1:0]        req_steps,
  output logic                     done,
  output logic                     resp_err,
  output logic                     busy,
  input  logic                     pll_locked,
  output logic [1:0]               phasesel,
  output logic                     phasedir,
  output logic                     phasestep,
  output logic [NCH*PHASE_W-1:0]   phase_o
);

  localparam int         CNT_W = $clog2(LOCK_TMO + SETUP_CYC + PULSE_CYC + HOLD_CYC + 1);
  localparam logic [2:0] NCH_L = 3'(NCH);

  pll_state_t        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [STEP_W-1:0] rem;
  logic              err_q, err_n;
  logic              accept, step_en, bad_ch;

  assign bad_ch    = {1'b0, phasesel} >= NCH_L;
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign phasestep = (state == PULSE);
  assign done      = (state == DONE);
  assign resp_err  = done & err_q;

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_W'(1);
    err_n   = err_q;
    accept  = 1'b0;
    step_en = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (req_valid) begin
          accept  = 1'b1;
          err_n   = 1'b0;
          state_n = SETUP;
        end
      end
      SETUP: begin
        // Requests that need no pulse are resolved in the first SETUP cycle.
        if (bad_ch) begin
          state_n = DONE;
          err_n   = 1'b1;
          cnt_n   = '0;
        end else if (rem == '0) begin
          state_n = DONE;
          cnt_n   = '0;
        end else if (cnt == CNT_W'(SETUP_CYC - 1)) begin
          state_n = PULSE;
          cnt_n   = '0;
        end
      end
      PULSE: begin
        if (cnt == CNT_W'(PULSE_CYC - 1)) begin
          state_n = HOLD;
          step_en = 1'b1;
          cnt_n   = '0;
        end
      end
      HOLD: begin
        if (cnt == CNT_W'(HOLD_CYC - 1)) begin
          state_n = LOCKWAIT;
          cnt_n   = '0;
        end
      end
      LOCKWAIT: begin
        if (pll_locked) begin
          state_n = (rem != '0) ? SETUP : DONE;
          cnt_n   = '0;
        end else if (cnt == CNT_W'(LOCK_TMO - 1)) begin
          state_n = DONE;
          err_n   = 1'b1;
          cnt_n   = '0;
        end
      end
      DONE: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      err_q    <= 1'b0;
      phasesel <= SEL_CLKOS;
      phasedir <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      err_q <= err_n;
      if (accept) begin
        phasesel <= req_ch;
        phasedir <= req_dir;
      end
    end
  end

  // Remaining-step count is pure data and is always reloaded on acceptance.
  always_ff @(posedge clk) begin
    if (accept)       rem <= req_steps;
    else if (step_en) rem <= rem - STEP_W'(1);
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    phase_wrap_counter #(
      .W (PHASE_W),
      .M (CH_MOD[c*PHASE_W +: PHASE_W])
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (step_en && (phasesel == 2'(c))),
      .dir   (phasedir),
      .q     (phase_o[c*PHASE_W +: PHASE_W])
    );
  end

endmodule

// File: tb/tb_pll_phase_stepper.sv
// Randomised self-checking bench for pll_phase_stepper against a
// behavioural step/phase model.
module tb_pll_phase_stepper;

  localparam int NCH     = 3;
  localparam int PHASE_W = 8;
  localparam int TMO     = 100;
  localparam int STEPCYC = 13;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_ch;
  logic               req_dir;
  logic [7:0]         req_steps;
  logic               done;
  logic               resp_err;
  logic               busy;
  logic               pll_locked;
  logic [1:0]         phasesel;
  logic               phasedir;
  logic               phasestep;
  logic [NCH*PHASE_W-1:0] phase_o;

  int cmp   = 0;
  int fails = 0;

  int mdl_mod[NCH] = '{80, 80, 16};
  int mdl_ph[NCH]  = '{0, 0, 0};

  int r_done_cyc, r_pulses, r_badw, r_unstable, r_ready_busy;
  bit r_err, r_ready_after, r_busy_done;

  pll_phase_stepper #(
    .NCH       (NCH),
    .PHASE_W   (PHASE_W),
    .CH_MOD    ({8'd16, 8'd80, 8'd80}),
    .STEP_W    (8),
    .SETUP_CYC (4),
    .PULSE_CYC (4),
    .HOLD_CYC  (4),
    .LOCK_TMO  (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ch     (req_ch),
    .req_dir    (req_dir),
    .req_steps  (req_steps),
    .done       (done),
    .resp_err   (resp_err),
    .busy       (busy),
    .pll_locked (pll_locked),
    .phasesel   (phasesel),
    .phasedir   (phasedir),
    .phasestep  (phasestep),
    .phase_o    (phase_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ph(input int c);
    return int'(phase_o[c*PHASE_W +: PHASE_W]);
  endfunction

  function automatic void model_apply(input int c, input bit dir, input int n);
    if (c >= NCH) return;
    if (dir) mdl_ph[c] = (mdl_ph[c] + n) % mdl_mod[c];
    else     mdl_ph[c] = (mdl_ph[c] + mdl_mod[c] - (n % mdl_mod[c])) % mdl_mod[c];
  endfunction

  // Issue one request from IDLE and observe it until done (bounded).
  task automatic run_req(input logic [1:0] ch, input bit dir, input logic [7:0] steps,
                         input int drop_after, input bit spurious);
    int cyc, hi;
    req_valid = 1'b1; req_ch = ch; req_dir = dir; req_steps = steps;
    tick();
    req_valid = 1'b0;
    cyc = 1; hi = 0;
    r_done_cyc = -1; r_err = 1'b0; r_pulses = 0; r_badw = 0; r_unstable = 0;
    r_ready_busy = 0; r_busy_done = 1'b0;
    while (cyc < 2000) begin
      if (phasesel !== ch || phasedir !== dir) r_unstable++;
      if (req_ready !== 1'b0 && done !== 1'b1) r_ready_busy++;
      if (phasestep === 1'b1) hi++;
      else if (hi > 0) begin
        r_pulses++;
        if (hi != 4) r_badw++;
        hi = 0;
        if (r_pulses == drop_after) pll_locked = 1'b0;
      end
      if (done === 1'b1) begin
        r_done_cyc  = cyc;
        r_err       = resp_err;
        r_busy_done = busy;
        break;
      end
      if (spurious && cyc >= 2 && cyc <= 6) begin
        req_valid = 1'b1; req_ch = 2'(~ch); req_dir = ~dir; req_steps = 8'd7;
      end else begin
        req_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    req_valid = 1'b0;
    tick();
    r_ready_after = req_ready;
  endtask

  task automatic check_phases(input string tag);
    for (int c = 0; c < NCH; c++) begin
      cmp++;
      if (ph(c) !== mdl_ph[c]) begin
        fails++;
        $display("FAIL %s phase ch%0d: got %0d expected %0d", tag, c, ph(c), mdl_ph[c]);
      end
    end
  endtask

  task automatic check_common(input string tag, input int exp_cyc, input bit exp_err,
                              input int exp_pulses);
    cmp++;
    if (r_done_cyc !== exp_cyc) begin
      fails++; $display("FAIL %s done_cycle: got %0d expected %0d", tag, r_done_cyc, exp_cyc);
    end
    cmp++;
    if (r_err !== exp_err) begin
      fails++; $display("FAIL %s resp_err: got %0d expected %0d", tag, r_err, exp_err);
    end
    cmp++;
    if (r_pulses !== exp_pulses) begin
      fails++; $display("FAIL %s pulses: got %0d expected %0d", tag, r_pulses, exp_pulses);
    end
    cmp++;
    if (r_badw !== 0 || r_unstable !== 0) begin
      fails++; $display("FAIL %s width/sel: bad_width=%0d unstable=%0d expected 0/0",
                        tag, r_badw, r_unstable);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_ch = 2'd0; req_dir = 1'b0; req_steps = 8'd0;
    pll_locked = 1'b1;
    repeat (3) tick();
    cmp++;
    if ({req_ready, done, resp_err, busy, phasestep, phasesel, phasedir} !== 8'b1000_0000) begin
      fails++;
      $display("FAIL reset_outputs: got ready=%b done=%b err=%b busy=%b step=%b sel=%0d dir=%b expected 1,0,0,0,0,0,0",
               req_ready, done, resp_err, busy, phasestep, phasesel, phasedir);
    end
    rst_n = 1'b1;
    tick();
    check_phases("reset");
  endtask

  task automatic test_advance();
    run_req(2'd1, 1'b1, 8'd3, 0, 1'b0);
    model_apply(1, 1'b1, 3);
    check_common("advance", 1 + 3*STEPCYC, 1'b0, 3);
    check_phases("advance");
    cmp++;
    if (ph(1) !== 3) begin
      fails++; $display("FAIL advance_ch1_abs: got %0d expected 3", ph(1));
    end
  endtask

  task automatic test_delay_wrap();
    run_req(2'd0, 1'b0, 8'd2, 0, 1'b0);
    model_apply(0, 1'b0, 2);
    check_common("delay_wrap", 1 + 2*STEPCYC, 1'b0, 2);
    cmp++;
    if (ph(0) !== 78) begin
      fails++; $display("FAIL delay_wrap_ch0: got %0d expected 78", ph(0));
    end
  endtask

  task automatic test_bad_channel();
    run_req(2'd3, 1'b1, 8'd4, 0, 1'b0);
    check_common("bad_channel", 2, 1'b1, 0);
    check_phases("bad_channel");
  endtask

  task automatic test_zero_steps();
    run_req(2'd2, 1'b1, 8'd0, 0, 1'b0);
    check_common("zero_steps", 2, 1'b0, 0);
    cmp++;
    if (r_ready_after !== 1'b1 || r_busy_done !== 1'b1) begin
      fails++; $display("FAIL zero_steps_ready: ready_after=%b busy_at_done=%b expected 1/1",
                        r_ready_after, r_busy_done);
    end
    check_phases("zero_steps");
  endtask

  task automatic test_lock_timeout();
    run_req(2'd2, 1'b1, 8'd5, 1, 1'b0);
    pll_locked = 1'b1;
    model_apply(2, 1'b1, 1);
    check_common("lock_timeout", 1 + STEPCYC - 1 + TMO, 1'b1, 1);
    check_phases("lock_timeout");
  endtask

  task automatic test_back_to_back();
    run_req(2'd0, 1'b1, 8'd2, 0, 1'b1);
    model_apply(0, 1'b1, 2);
    check_common("ignored_req", 1 + 2*STEPCYC, 1'b0, 2);
    cmp++;
    if (r_ready_busy !== 0) begin
      fails++; $display("FAIL ignored_req_ready: ready high %0d busy cycles expected 0", r_ready_busy);
    end
    check_phases("ignored_req");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [1:0] ch;
      bit dir;
      int n;
      ch  = 2'($urandom_range(0, 3));
      dir = 1'($urandom_range(0, 1));
      n   = $urandom_range(0, 40);
      run_req(ch, dir, 8'(n), 0, 1'b0);
      model_apply(int'(ch), dir, n);
      if (int'(ch) >= NCH)
        check_common("random_badch", 2, 1'b1, 0);
      else if (n == 0)
        check_common("random_zero", 2, 1'b0, 0);
      else
        check_common("random_steps", 1 + n*STEPCYC, 1'b0, n);
      check_phases("random");
    end
  endtask

  task automatic test_reset_mid();
    int k;
    req_valid = 1'b1; req_ch = 2'd1; req_dir = 1'b1; req_steps = 8'd5;
    tick();
    req_valid = 1'b0;
    k = 0;
    while (phasestep !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    cmp++;
    if (phasestep !== 1'b1) begin
      fails++; $display("FAIL reset_mid_pulse_seen: got %b expected 1", phasestep);
    end
    rst_n = 1'b0;
    tick();
    cmp++;
    if (phasestep !== 1'b0) begin
      fails++; $display("FAIL reset_mid_step_low: got %b expected 0", phasestep);
    end
    for (int c = 0; c < NCH; c++) mdl_ph[c] = 0;
    check_phases("reset_mid");
    rst_n = 1'b1;
    tick();
    cmp++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_mid_ready: ready=%b busy=%b expected 1/0", req_ready, busy);
    end
  endtask

  initial begin
    test_reset();
    test_advance();
    test_delay_wrap();
    test_bad_channel();
    test_zero_steps();
    test_lock_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end

endmodule
